// File: rtl/fir_out_serializer.sv
// Requantizing buffer that turns 3-lane FIR output groups into a
// one-sample-per-cycle serial stream with valid/ready on both sides.
module fir_out_serializer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  y0,
  input  logic signed [IN_W-1:0]  y1,
  input  logic signed [IN_W-1:0]  y2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [1:0]              out_phase,
  output logic                    out_sat,
  output logic [15:0]             sat_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic signed [IN_W:0] RND =
    (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAXV =
    (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W:0] MINV =
    -MAXV - (IN_W+1)'(1);

  // Returns {sat, data}; math in IN_W+1 bits so rounding cannot wrap.
  function automatic logic [OUT_W:0] requant(
    input logic signed [IN_W-1:0] y
  );
    logic signed [IN_W:0] r;
    r = ($signed({y[IN_W-1], y}) + RND) >>> SHIFT;
    if (r > MAXV) begin
      requant = {1'b1, MAXV[OUT_W-1:0]};
    end else if (r < MINV) begin
      requant = {1'b1, MINV[OUT_W-1:0]};
    end else begin
      requant = {1'b0, r[OUT_W-1:0]};
    end
  endfunction

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       phase;
  logic [15:0]      sat_cnt_q;

  logic [OUT_W-1:0] mem_d [DEPTH][3];
  logic             mem_s [DEPTH][3];

  logic signed [IN_W-1:0] lane [3];
  logic [OUT_W-1:0] q_d [3];
  logic [2:0]       q_s;

  logic             push;
  logic             xfer;
  logic             pop;
  logic [1:0]       grp_sat;
  logic [16:0]      sat_sum;
  logic [OUT_W-1:0] head_d;
  logic             head_s;

  assign lane[0] = y0;
  assign lane[1] = y1;
  assign lane[2] = y2;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      {q_s[i], q_d[i]} = requant(lane[i]);
    end
  end

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (phase == 2'd2);

  assign grp_sat = 2'(q_s[0]) + 2'(q_s[1]) + 2'(q_s[2]);
  assign sat_sum = {1'b0, sat_cnt_q} + {15'b0, grp_sat};

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        mem_d[wr_ptr][i] <= q_d[i];
        mem_s[wr_ptr][i] <= q_s[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      phase     <= 2'd0;
      sat_cnt_q <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (xfer) begin
        phase <= pop ? 2'd0 : phase + 2'd1;
      end
      if (push) begin
        sat_cnt_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end

  always_comb begin
    head_d = mem_d[rd_ptr][0];
    head_s = mem_s[rd_ptr][0];
    case (phase)
      2'd1: begin
        head_d = mem_d[rd_ptr][1];
        head_s = mem_s[rd_ptr][1];
      end
      2'd2: begin
        head_d = mem_d[rd_ptr][2];
        head_s = mem_s[rd_ptr][2];
      end
      default: ;
    endcase
  end

  assign out_data  = out_valid ? $signed(head_d) : '0;
  assign out_phase = out_valid ? phase : 2'd0;
  assign out_sat   = out_valid && head_s;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Directed bench for fir_out_serializer: rounding, saturation,
// backpressure, streaming across pointer wrap and async reset.
module tb_fir_out_serializer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] y0, y1, y2;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [1:0]         out_phase;
  logic               out_sat;
  logic [15:0]        sat_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_out_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_phase (out_phase),
    .out_sat   (out_sat),
    .sat_count (sat_count)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    y0 = 0; y1 = 0; y2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 ||
        out_phase !== 2'd0 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b d=%0d p=%0d s=%0b exp 0 0 0 0",
               out_valid, out_data, out_phase, out_sat);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
    checks++;
    if (sat_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_sat_count got=%0d exp=0", sat_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rounding;
    int exp_d [3] = '{1, 2, -1};
    out_ready = 1'b1;
    in_valid = 1'b1;
    y0 = 32768; y1 = 49152; y2 = -49152;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(exp_d[i]) ||
          out_phase !== 2'(i) || out_sat !== 1'b0) begin
        failures++;
        $display("FAIL round_%0d got v=%0b d=%0d p=%0d s=%0b exp 1 %0d %0d 0",
                 i, out_valid, out_data, out_phase, out_sat, exp_d[i], i);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0) begin
      failures++;
      $display("FAIL round_idle got v=%0b d=%0d exp 0 0",
               out_valid, out_data);
    end
  endtask

  task automatic test_saturation;
    int exp_d [3] = '{32767, -32768, 0};
    bit exp_s [3] = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    in_valid = 1'b1;
    y0 = 32'h7FFFFFFF; y1 = 32'h80000000; y2 = 0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sat_count !== 16'd2) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=2", sat_count);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(exp_d[i]) ||
          out_phase !== 2'(i) || out_sat !== exp_s[i]) begin
        failures++;
        $display("FAIL sat_%0d got v=%0b d=%0d p=%0d s=%0b exp 1 %0d %0d %0b",
                 i, out_valid, out_data, out_phase, out_sat,
                 exp_d[i], i, exp_s[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_idle got v=%0b exp 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    bit go;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_fill_ready_%0d got=%0b exp=1", k, in_ready);
      end
      in_valid = 1'b1;
      y0 = (k * 3 + 1) * 32768;
      y1 = (k * 3 + 2) * 32768;
      y2 = (k * 3 + 3) * 32768;
      @(negedge clk);
    end
    y0 = 13 * 32768; y1 = 14 * 32768; y2 = 15 * 32768;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_data !== 16'sd1 || out_phase !== 2'd0) begin
        failures++;
        $display("FAIL bp_hold_%0d got r=%0b v=%0b d=%0d p=%0d exp 0 1 1 0",
                 c, in_ready, out_valid, out_data, out_phase);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(i + 1) ||
          out_phase !== 2'(i % 3)) begin
        failures++;
        $display("FAIL bp_drain_%0d got v=%0b d=%0d p=%0d exp 1 %0d %0d",
                 i, out_valid, out_data, out_phase, i + 1, i % 3);
      end
      go = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (go) in_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || in_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_end got out_valid=%0b in_valid=%0b exp 0 0",
               out_valid, in_valid);
    end
    checks++;
    if (sat_count !== 16'd2) begin
      failures++;
      $display("FAIL bp_sat_count got=%0d exp=2", sat_count);
    end
  endtask

  task automatic test_streaming;
    int q [$];
    int g = 0;
    int nv = 0;
    int rdy_hi = 0;
    int bad = 0;
    int seen = 0;
    int exp_v;
    bit started = 0;
    bit go;
    out_ready = 1'b1;
    in_valid = 1'b1;
    y0 = (0 - 20) * 32768; y1 = (1 - 20) * 32768; y2 = (2 - 20) * 32768;
    for (int cyc = 0; cyc < 48; cyc++) begin
      if (out_valid === 1'b1) begin
        started = 1;
        if (q.size() == 0) begin
          bad++;
        end else begin
          exp_v = q.pop_front();
          seen++;
          if (out_data !== 16'(exp_v)) begin
            bad++;
            $display("FAIL stream_data got=%0d exp=%0d", out_data, exp_v);
          end
        end
      end else if (started) begin
        nv++;
      end
      if (cyc >= 18 && in_ready === 1'b1) rdy_hi++;
      go = in_ready;
      if (go) for (int i = 0; i < 3; i++) q.push_back(g * 3 + i - 20);
      @(posedge clk);
      #1;
      if (go) begin
        g++;
        y0 = (g * 3 + 0 - 20) * 32768;
        y1 = (g * 3 + 1 - 20) * 32768;
        y2 = (g * 3 + 2 - 20) * 32768;
      end
      if (cyc == 47) in_valid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      if (out_valid !== 1'b1) begin
        bad++;
      end else begin
        exp_v = q.pop_front();
        seen++;
        if (out_data !== 16'(exp_v)) begin
          bad++;
          $display("FAIL stream_drain got=%0d exp=%0d", out_data, exp_v);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || seen != g * 3) begin
      failures++;
      $display("FAIL stream_order got errors=%0d samples=%0d exp 0 %0d",
               bad, seen, g * 3);
    end
    checks++;
    if (nv != 0) begin
      failures++;
      $display("FAIL stream_bubbles got=%0d exp=0", nv);
    end
    checks++;
    if (rdy_hi != 10) begin
      failures++;
      $display("FAIL stream_in_ready_rate got=%0d exp=10", rdy_hi);
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_empty got left=%0d v=%0b exp 0 0",
               q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1;
    y0 = 100 * 32768; y1 = 101 * 32768; y2 = 102 * 32768;
    @(negedge clk);
    y0 = 200 * 32768; y1 = 201 * 32768; y2 = 202 * 32768;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_phase !== 2'd1 || out_data !== 16'sd101) begin
      failures++;
      $display("FAIL rstmid_pre got p=%0d d=%0d exp 1 101",
               out_phase, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_phase !== 2'd0 ||
        out_sat !== 1'b0 || in_ready !== 1'b1 || sat_count !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_async got v=%0b d=%0d p=%0d s=%0b r=%0b c=%0d exp 0 0 0 0 1 0",
               out_valid, out_data, out_phase, out_sat, in_ready, sat_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    y0 = 7 * 32768; y1 = 8 * 32768; y2 = 9 * 32768;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(7 + i) ||
          out_phase !== 2'(i)) begin
        failures++;
        $display("FAIL rstmid_post_%0d got v=%0b d=%0d p=%0d exp 1 %0d %0d",
                 i, out_valid, out_data, out_phase, 7 + i, i);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_flushed got v=%0b exp 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_out_serializer.md
FIR_OUT_SERIALIZER -- requirements
Module: fir_out_serializer

Interface
REQ-001 The block SHALL have the following parameters: IN_W, default 32, width of each parallel filter output sample.
REQ-002 The block SHALL have parameter OUT_W, default 16, width of each serialized output sample.
REQ-003 The block SHALL have parameter SHIFT, default 15, the arithmetic right-shift applied during requantization, with 1 <= SHIFT < IN_W.
REQ-004 The block SHALL have parameter DEPTH, default 4, the buffer capacity in 3-sample groups, a power of two >= 2.
REQ-005 The block SHALL have the following ports: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 in_valid, input, 1: the parallel group y0/y1/y2 is valid.
REQ-008 in_ready, output, 1: the block can accept a group this cycle.
REQ-009 y0, y1, y2, input, IN_W each, signed: time-ordered samples n, n+1 and n+2 from the 3-path FIR.
REQ-010 out_valid, output, 1: out_data holds a valid sample.
REQ-011 out_ready, input, 1: the downstream consumer accepts out_data.
REQ-012 out_data, output, OUT_W, signed: the requantized serial sample.
REQ-013 out_phase, output, 2: source lane of out_data (0=y0, 1=y1, 2=y2).
REQ-014 out_sat, output, 1: out_data was saturated.
REQ-015 sat_count, output, 16: count of saturated samples accepted since reset.

Function
REQ-016 A group SHALL be written into the buffer when in_valid && in_ready at a clock edge; a group SHALL NOT be written otherwise.
REQ-017 in_ready SHALL be 1 whenever stored groups < DEPTH, combinationally from the registered count, with no dependence on out_ready (no pass-through when full).
REQ-018 Each lane SHALL be requantized at write time: r = (y + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 signed bits (round half up, no wrap).
REQ-019 r SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and a per-sample sat bit SHALL be stored alongside it.
REQ-020 out_valid SHALL be 1 whenever stored groups > 0; out_data, out_phase and out_sat SHALL come from the head group at the current phase.
REQ-021 A sample SHALL be transferred on out_valid && out_ready.
REQ-022 On each transfer, phase SHALL advance 0->1->2; on a transfer at phase 2, the head group SHALL be popped and phase SHALL return to 0.
REQ-023 While out_valid && !out_ready, out_data, out_phase and out_sat SHALL remain stable.
REQ-024 Latency: a group accepted at edge N into an empty buffer SHALL present its y0 result with out_valid=1 in the cycle after edge N.
REQ-025 A simultaneous push and final-sample pop SHALL leave the count unchanged, with pointers wrapping modulo DEPTH.
REQ-026 When out_valid=0, out_data SHALL be 0, out_phase SHALL be 0 and out_sat SHALL be 0.
REQ-027 sat_count SHALL increment by the number of saturated lanes (0-3) in each accepted group, saturating at 0xFFFF without wrapping.
REQ-028 Sustained throughput SHALL be one output sample per cycle; input acceptance is therefore limited to an average of 1 group per 3 cycles.

Reset
REQ-029 While rst_n=0, and immediately on its assertion regardless of clock, the write pointer, read pointer, count, phase and sat_count SHALL be cleared to 0.
REQ-030 While rst_n=0, out_valid SHALL be 0, out_data SHALL be 0, out_phase SHALL be 0, out_sat SHALL be 0 and in_ready SHALL be 1.
REQ-031 Reset asserted mid-group SHALL discard all buffered groups and the partial group; buffer memory contents need no reset.

Verification
REQ-032 Rounding (SHIFT=15, out_ready=1): push y0=32768, y1=49152, y2=-49152 -> out_data 1, 2, -1 on three consecutive cycles, out_phase 0, 1, 2, out_sat 0.
REQ-033 Saturation: push y0=0x7FFFFFFF, y1=0x80000000, y2=0 -> out_data 32767 (out_sat=1), -32768 (out_sat=1), 0 (out_sat=0), with sat_count=2.
REQ-034 Backpressure: with out_ready=0, push 4 distinct groups -> in_ready=0 after the 4th accept and a 5th group is held without loss; out_data stays constant; then with out_ready=1, 12 samples drain in order, followed by the 5th group.
REQ-035 Streaming: in_valid=1 constantly with out_ready=1 -> out_valid=1 every cycle after the first, in_ready pulses every 3rd cycle in steady state, and no sample is dropped or duplicated across pointer wrap.
REQ-036 Reset mid-operation: assert rst_n=0 at out_phase=1 with 2 groups stored -> all outputs reach their reset values without a clock edge; after release the next pushed group emerges first, starting at phase 0.
